uart_hex_sender: RTL and testbench

UART_HEX_SENDER -- requirements
Module: uart_hex_sender

---
 rtl/uart_hex_sender.sv | 196 +++++++++++++++++++
 tb/tb_uart_hex_sender.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_sender.sv
// ---------------------------------------------------------------------------
// uart_hex_sender
//
// Sends a 64-bit record to a byte-wide UART transmitter as printable ASCII.
// The output is lowercase hex, most-significant nibble first, and each record
// ends with CR LF.
//   Two-word format (pc_print_sel=0): "hhhhhhhh hhhhhhhh\r\n"  (19 characters)
//   One-word format (pc_print_sel=1): "hhhhhhhh\r\n"           (10 characters)
//
// Ports
//   clk             : single clock; all state changes happen on its rising edge
//   rst_n           : asynchronous active-low reset
//   rdata_snd_start : one-cycle request to send a record
//   rdata_snd[63:0] : record payload, sampled only in the request cycle
//   pc_print_sel    : record format, sampled only in the request cycle
//   snd_abort       : drops the record in progress
//   tx_busy         : UART transmitter busy
//   tx_start        : one-cycle pulse that launches the character on tx_data
//   tx_data[7:0]    : ASCII character; held from one tx_start to the next
//   flushing_wq     : one-cycle pulse after the last character of a record
//   snd_overrun     : one-cycle pulse when a request arrives while busy
//   snd_busy        : high whenever a record is in progress
// ---------------------------------------------------------------------------
module uart_hex_sender (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    input  logic        snd_abort,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        flushing_wq,
    output logic        snd_overrun,
    output logic        snd_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_HOLD = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] LEN_TWO_WORD = 5'd19;
    localparam logic [4:0] LEN_ONE_WORD = 5'd10;
    localparam logic [7:0] CH_SPACE     = 8'h20;
    localparam logic [7:0] CH_CR        = 8'h0D;
    localparam logic [7:0] CH_LF        = 8'h0A;

    state_t      state_q, state_d;
    logic [63:0] shreg_q, shreg_d;
    logic        one_word_q, one_word_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;

    // -----------------------------------------------------------------------
    // Character generation: decoded from the character counter and format.
    // -----------------------------------------------------------------------
    logic [4:0] rec_len;
    logic       chars_left;
    logic       is_hex;
    logic [3:0] cur_nibble;
    logic [7:0] hex_char;
    logic [7:0] cur_char;

    assign rec_len    = one_word_q ? LEN_ONE_WORD : LEN_TWO_WORD;
    assign chars_left = (cnt_q < rec_len);

    // The register always shifts left, so the next digit of the active word
    // sits at its top nibble: [31:28] in one-word format, [63:60] otherwise.
    assign cur_nibble = one_word_q ? shreg_q[31:28] : shreg_q[63:60];

    // 0-9 -> '0'..'9', 10-15 -> 'a'..'f' ('a' - 10 = 0x57).
    assign hex_char = (cur_nibble < 4'd10) ? (8'h30 + {4'h0, cur_nibble})
                                           : (8'h57 + {4'h0, cur_nibble});

    always_comb begin
        is_hex = 1'b0;
        if (one_word_q) begin
            is_hex = (cnt_q < 5'd8);
        end else begin
            is_hex = (cnt_q < 5'd8) || ((cnt_q >= 5'd9) && (cnt_q < 5'd17));
        end
    end

    always_comb begin
        cur_char = CH_LF;
        if (is_hex) begin
            cur_char = hex_char;
        end else if (one_word_q) begin
            cur_char = (cnt_q == 5'd8) ? CH_CR : CH_LF;
        end else if (cnt_q == 5'd8) begin
            cur_char = CH_SPACE;
        end else if (cnt_q == 5'd17) begin
            cur_char = CH_CR;
        end else begin
            cur_char = CH_LF;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        one_word_d  = one_word_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_start    = 1'b0;
        flushing_wq = 1'b0;
        snd_overrun = 1'b0;

        // Any request outside idle is dropped and reported.
        if ((state_q != S_IDLE) && rdata_snd_start) begin
            snd_overrun = 1'b1;
        end

        if ((state_q != S_IDLE) && snd_abort) begin
            // Abort wins over everything else, including a new request.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // An abort in idle has no record to drop, but it still
                    // masks a request arriving in the same cycle.
                    if (rdata_snd_start && !snd_abort) begin
                        shreg_d    = rdata_snd;
                        one_word_d = pc_print_sel;
                        cnt_d      = 5'd0;
                        state_d    = S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start  = 1'b1;
                        tx_data_d = cur_char;
                        if (cnt_q != LEN_TWO_WORD) begin
                            cnt_d = cnt_q + 5'd1;
                        end
                        // Only hex digits consume payload bits.
                        if (is_hex) begin
                            shreg_d = {shreg_q[59:0], 4'h0};
                        end
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Gives the transmitter one cycle to raise tx_busy after
                    // tx_start; tx_busy is deliberately ignored here.
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        state_d = chars_left ? S_SEND : S_DONE;
                    end
                end
                S_DONE: begin
                    flushing_wq = 1'b1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // The launched character is visible in the tx_start cycle itself. After
    // that the register holds it until the next launch.
    assign tx_data  = tx_start ? cur_char : tx_data_q;
    assign snd_busy = (state_q != S_IDLE);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= 64'h0;
            one_word_q <= 1'b0;
            cnt_q      <= 5'd0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            one_word_q <= one_word_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_hex_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_sender
//
// Randomized self-checking bench for uart_hex_sender. A UART model drives
// tx_busy after each tx_start. The expected character stream for each record
// is formatted directly from the payload with $sformatf.
// ---------------------------------------------------------------------------
module tb_uart_hex_sender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdata_snd_start = 1'b0;
    logic [63:0] rdata_snd = 64'h0;
    logic        pc_print_sel = 1'b0;
    logic        snd_abort = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        flushing_wq;
    logic        snd_overrun;
    logic        snd_busy;

    uart_hex_sender dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdata_snd_start (rdata_snd_start),
        .rdata_snd       (rdata_snd),
        .pc_print_sel    (pc_print_sel),
        .snd_abort       (snd_abort),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .flushing_wq     (flushing_wq),
        .snd_overrun     (snd_overrun),
        .snd_busy        (snd_busy)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    byte        got_q[$];
    int         start_cnt = 0;
    int         flush_cnt = 0;
    int         ovr_cnt   = 0;
    int         excl_viol = 0;
    int         stab_viol = 0;
    logic [7:0] last_char = 8'h00;
    bit         have_last = 1'b0;
    bit         saw_start = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            have_last = 1'b0;
        end else begin
            if (tx_start) begin
                got_q.push_back(tx_data);
                start_cnt++;
                last_char = tx_data;
                have_last = 1'b1;
                saw_start = 1'b1;
            end else if (have_last && (tx_data !== last_char)) begin
                stab_viol++;
            end
            if (flushing_wq) flush_cnt++;
            if (snd_overrun) ovr_cnt++;
            if (tx_start && flushing_wq) excl_viol++;
        end
    end

    // ---------------- UART busy model ----------------
    int busy_max  = 0;
    bit hold_busy = 1'b0;
    int busy_left = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (saw_start) begin
            saw_start = 1'b0;
            busy_left = int'($urandom_range(busy_max));
        end else if (busy_left > 0) begin
            busy_left--;
        end
        tx_busy = hold_busy || (busy_left > 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic [63:0] d, input logic sel);
        rdata_snd       = d;
        pc_print_sel    = sel;
        rdata_snd_start = 1'b1;
        @(posedge clk);
        #1;
        rdata_snd_start = 1'b0;
        rdata_snd       = {$urandom, $urandom};
        pc_print_sel    = 1'($urandom_range(1));
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, ".reached"}, 64'(start_cnt >= target), 64'd1);
    endtask

    task automatic wait_flush(input int target, input int budget, input string tag);
        int n = 0;
        while (flush_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, ".done"}, 64'(flush_cnt >= target), 64'd1);
    endtask

    // Reference model: the record is simply its printf-formatted text.
    function automatic string expected_text(input logic [63:0] d, input logic sel);
        if (sel) return $sformatf("%08h\r\n", d[31:0]);
        return $sformatf("%08h %08h\r\n", d[63:32], d[31:0]);
    endfunction

    task automatic check_record(input string tag, input logic [63:0] d, input logic sel,
                                input int flush_base);
        string s;
        wait_flush(flush_base + 1, 800, tag);
        repeat (4) @(posedge clk);
        #1;
        s = expected_text(d, sel);
        check_val({tag, ".len"}, 64'(got_q.size()), 64'(s.len()));
        for (int i = 0; i < s.len() && i < got_q.size(); i++) begin
            check_val($sformatf("%s.ch%0d", tag, i), 64'(got_q[i]), 64'(s[i]));
        end
        check_val({tag, ".flush"}, 64'(flush_cnt - flush_base), 64'd1);
        $display("record %s data=%016h sel=%0d chars=%0d", tag, d, sel, got_q.size());
    endtask

    initial begin
        logic [63:0] d;
        logic        sel;
        int          fb, sb, ob;

        // Reset values must appear without any clock edge.
        #3;
        check_val("rst.tx_start", 64'(tx_start), 64'd0);
        check_val("rst.tx_data", 64'(tx_data), 64'h00);
        check_val("rst.flush", 64'(flushing_wq), 64'd0);
        check_val("rst.overrun", 64'(snd_overrun), 64'd0);
        check_val("rst.busy", 64'(snd_busy), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two-word record on the first edge after reset release.
        got_q.delete(); fb = flush_cnt;
        send_req(64'h0123456789ABCDEF, 1'b0);
        check_val("latency", 64'(tx_start), 64'd1);
        check_record("two_word", 64'h0123456789ABCDEF, 1'b0, fb);

        // One-word record.
        got_q.delete(); fb = flush_cnt;
        send_req(64'hFFFFFFFF00000100, 1'b1);
        check_record("one_word", 64'hFFFFFFFF00000100, 1'b1, fb);

        // Backpressure: transmitter busy for 50 cycles.
        got_q.delete(); fb = flush_cnt;
        hold_busy = 1'b1; tx_busy = 1'b1;
        d = {$urandom, $urandom};
        send_req(d, 1'b0);
        sb = start_cnt;
        repeat (50) @(posedge clk);
        #1;
        check_val("bp.no_start", 64'(start_cnt - sb), 64'd0);
        hold_busy = 1'b0; tx_busy = 1'b0;
        #1;
        check_val("bp.start", 64'(tx_start), 64'd1);
        check_record("bp", d, 1'b0, fb);

        // Abort during the 5th character, then a full record.
        busy_max = 2;
        got_q.delete(); fb = flush_cnt; sb = start_cnt;
        send_req({$urandom, $urandom}, 1'b0);
        wait_starts(sb + 5, 300, "abort.wait");
        snd_abort = 1'b1;
        @(posedge clk);
        #1;
        snd_abort = 1'b0;
        check_val("abort.idle", 64'(snd_busy), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check_val("abort.starts", 64'(start_cnt - sb), 64'd5);
        check_val("abort.noflush", 64'(flush_cnt - fb), 64'd0);
        got_q.delete(); fb = flush_cnt;
        d = {$urandom, $urandom};
        send_req(d, 1'b0);
        check_record("after_abort", d, 1'b0, fb);

        // Abort together with a request while idle: the request is ignored.
        sb = start_cnt;
        snd_abort = 1'b1; rdata_snd_start = 1'b1; rdata_snd = 64'h1;
        @(posedge clk);
        #1;
        snd_abort = 1'b0; rdata_snd_start = 1'b0;
        check_val("idle_abort.busy", 64'(snd_busy), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check_val("idle_abort.starts", 64'(start_cnt - sb), 64'd0);

        // Overrun: a second request mid-record is dropped.
        got_q.delete(); fb = flush_cnt; ob = ovr_cnt;
        d = {$urandom, $urandom};
        send_req(d, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rdata_snd = ~d; pc_print_sel = 1'b1; rdata_snd_start = 1'b1;
        @(posedge clk);
        #1;
        rdata_snd_start = 1'b0;
        check_record("overrun", d, 1'b0, fb);
        check_val("overrun.pulses", 64'(ovr_cnt - ob), 64'd1);

        // Reset after 3 characters.
        sb = start_cnt;
        send_req({$urandom, $urandom}, 1'b0);
        wait_starts(sb + 3, 300, "rst_mid.wait");
        rst_n = 1'b0;
        #1;
        check_val("rst_mid.tx_start", 64'(tx_start), 64'd0);
        check_val("rst_mid.tx_data", 64'(tx_data), 64'h00);
        check_val("rst_mid.flush", 64'(flushing_wq), 64'd0);
        check_val("rst_mid.overrun", 64'(snd_overrun), 64'd0);
        check_val("rst_mid.busy", 64'(snd_busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb = start_cnt; fb = flush_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_val("rst_mid.quiet_start", 64'(start_cnt - sb), 64'd0);
        check_val("rst_mid.quiet_flush", 64'(flush_cnt - fb), 64'd0);

        // Random records with random transmitter timing.
        for (int k = 0; k < 8; k++) begin
            busy_max = int'($urandom_range(3));
            d   = {$urandom, $urandom};
            sel = 1'($urandom_range(1));
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
            got_q.delete(); fb = flush_cnt;
            send_req(d, sel);
            check_record($sformatf("rand%0d", k), d, sel, fb);
        end

        check_val("excl", 64'(excl_viol), 64'd0);
        check_val("stable", 64'(stab_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
